// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART handshake bundle for uart_tx_arbiter.
// The arbiter connects through the master modport; the requesters and UART sit on the slave side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           uart_send_data;
  logic                 uart_start;
  logic                 uart_busy;
  logic [GW-1:0]        grant_id;
  logic                 active;
  logic                 err;

  modport master (
    input  req, req_data, uart_busy,
    output ack, uart_send_data, uart_start, grant_id, active, err
  );

  modport slave (
    output req, req_data, uart_busy,
    input  ack, uart_send_data, uart_start, grant_id, active, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_TAG_EN to precede every granted byte with a tag byte (TAG_BASE + grant_id).
module uart_tx_arbiter #(
  parameter int         NUM_REQ     = 4,
  parameter logic [7:0] TAG_BASE    = 8'hF0,
  parameter int         WAIT_HI_MAX = 15
) (
  input  logic               clock,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (WAIT_HI_MAX > 1) ? $clog2(WAIT_HI_MAX) : 1;
  localparam logic [CW-1:0]      HI_LAST = CW'(WAIT_HI_MAX - 1);
  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef UART_ARB_TAG_EN
    TAG_START,
    TAG_HI,
    TAG_LO,
`endif
    DATA_START,
    DATA_HI,
    DATA_LO
  } state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] hi_cnt;
`ifdef UART_ARB_TAG_EN
  logic [7:0]    data_latch;
`endif

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;
  logic [7:0]    win_byte;

  // First requester found scanning upward from last_grant+1, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((32'(last_grant) + off) % NUM_REQ);
      if (!win_found && 1'(bus.req >> cand)) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_byte = 8'(bus.req_data >> {win_idx, 3'b000});
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= IDLE;
      last_grant         <= GW'(NUM_REQ - 1);
      hi_cnt             <= '0;
      bus.ack            <= '0;
      bus.uart_start     <= 1'b0;
      bus.uart_send_data <= '0;
      bus.grant_id       <= '0;
      bus.active         <= 1'b0;
      bus.err            <= 1'b0;
`ifdef UART_ARB_TAG_EN
      data_latch         <= '0;
`endif
    end else begin
      bus.ack        <= '0;
      bus.uart_start <= 1'b0;
      bus.err        <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found && !bus.uart_busy) begin
            bus.ack      <= ACK_ONE << win_idx;
            bus.grant_id <= win_idx;
            last_grant   <= win_idx;
            bus.active   <= 1'b1;
`ifdef UART_ARB_TAG_EN
            data_latch         <= win_byte;
            bus.uart_send_data <= TAG_BASE + 8'(win_idx);
            state              <= TAG_START;
`else
            bus.uart_send_data <= win_byte;
            state              <= DATA_START;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG_START: begin
          bus.uart_start <= 1'b1;
          hi_cnt         <= '0;
          state          <= TAG_HI;
        end
        TAG_HI: begin
          if (bus.uart_busy) begin
            state <= TAG_LO;
          end else if (hi_cnt == HI_LAST) begin
            bus.err    <= 1'b1;
            bus.active <= 1'b0;
            state      <= IDLE;
          end else begin
            hi_cnt <= hi_cnt + 1'b1;
          end
        end
        TAG_LO: begin
          if (!bus.uart_busy) begin
            bus.uart_send_data <= data_latch;
            state              <= DATA_START;
          end
        end
`endif
        DATA_START: begin
          bus.uart_start <= 1'b1;
          hi_cnt         <= '0;
          state          <= DATA_HI;
        end
        // The UART has WAIT_HI_MAX cycles, counted from entry, to raise busy.
        DATA_HI: begin
          if (bus.uart_busy) begin
            state <= DATA_LO;
          end else if (hi_cnt == HI_LAST) begin
            bus.err    <= 1'b1;
            bus.active <= 1'b0;
            state      <= IDLE;
          end else begin
            hi_cnt <= hi_cnt + 1'b1;
          end
        end
        DATA_LO: begin
          if (!bus.uart_busy) begin
            bus.active <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          bus.active <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized request bursts,
// compared against a round-robin reference model and a behavioural UART receiver.
module tb_uart_tx_arbiter;
  localparam int         NUM_REQ     = 4;
  localparam int         WAIT_HI_MAX = 15;
  localparam logic [7:0] TAG_BASE    = 8'hF0;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .TAG_BASE   (TAG_BASE),
    .WAIT_HI_MAX(WAIT_HI_MAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Behavioural UART transmitter: picks up the byte on uart_start, raises busy after a
  // random latency and holds it for a random frame length.
  logic uart_en    = 1'b1;
  logic busy_force = 1'b0;
  logic busy_m     = 1'b0;
  logic [7:0] rx_q[$];
  int lat, frame;

  assign bus.uart_busy = busy_m | busy_force;

  initial begin
    forever begin
      @(negedge clock);
      if (bus.uart_start === 1'b1 && uart_en) begin
        rx_q.push_back(bus.uart_send_data);
        lat   = int'($urandom_range(2, 0));
        frame = int'($urandom_range(6, 3));
        repeat (lat) @(negedge clock);
        busy_m = 1'b1;
        repeat (frame) @(negedge clock);
        busy_m = 1'b0;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int ack_log[$], gid_log[$], start_log[$], err_log[$];
  int exp_ids[$];
  logic [7:0] exp_rx[$];
  int model_last = NUM_REQ - 1;
  bit hold_mode  = 1'b0;
  int target     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ack_log.delete(); gid_log.delete(); start_log.delete(); err_log.delete();
    exp_ids.delete(); exp_rx.delete(); rx_q.delete();
  endtask

  // One clock; observe at the falling edge and let requesters drop req once acked.
  task automatic step();
    logic [NUM_REQ-1:0] m;
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (bus.uart_start === 1'b1) start_log.push_back(cyc);
    if (bus.err === 1'b1) err_log.push_back(cyc);
    if (bus.ack !== '0) begin
      check("ack_onehot", 32'($countones(bus.ack)), 32'd1);
      for (int i = 0; i < NUM_REQ; i++) begin
        m = NUM_REQ'(1) << i;
        if ((bus.ack & m) != '0) begin
          ack_log.push_back(i);
          gid_log.push_back(int'(bus.grant_id));
          if (!hold_mode) bus.req = bus.req & ~m;
        end
      end
      if (hold_mode && ack_log.size() >= target) bus.req = '0;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ack"},    32'(bus.ack),            32'd0);
    check({tag, "_start"},  32'(bus.uart_start),     32'd0);
    check({tag, "_err"},    32'(bus.err),            32'd0);
    check({tag, "_active"}, 32'(bus.active),         32'd0);
    check({tag, "_data"},   32'(bus.uart_send_data), 32'd0);
    check({tag, "_gid"},    32'(bus.grant_id),       32'd0);
  endtask

  // Reference: each grant goes to the first pending requester after the previous grant, cyclically.
  task automatic model_expect(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*8-1:0] data,
                              input bit hold, input int count);
    logic [NUM_REQ-1:0] pend;
    int cur, pick;
    pend = mask;
    cur  = model_last;
    for (int g = 0; g < count; g++) begin
      pick = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (pick < 0 && ((pend >> ((cur + k) % NUM_REQ)) & 1) != 0) pick = (cur + k) % NUM_REQ;
      if (pick >= 0) begin
        exp_ids.push_back(pick);
        if (TAG_ON) exp_rx.push_back(TAG_BASE + 8'(pick));
        exp_rx.push_back(8'(data >> (8 * pick)));
        if (!hold) pend = pend & ~(NUM_REQ'(1) << pick);
        cur = pick;
      end
    end
    model_last = cur;
  endtask

  task automatic wait_done(input string tag, input int count);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((ack_log.size() < count || bus.active === 1'b1 || bus.uart_busy === 1'b1) && n < 4000);
    check({tag, "_finished"}, 32'(n < 4000), 32'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, "_ack_count"}, 32'(ack_log.size()), 32'(exp_ids.size()));
    for (int k = 0; k < exp_ids.size() && k < ack_log.size(); k++) begin
      check($sformatf("%s_ack%0d", tag, k), 32'(ack_log[k]), 32'(exp_ids[k]));
      check($sformatf("%s_gid%0d", tag, k), 32'(gid_log[k]), 32'(exp_ids[k]));
    end
    check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_rx.size()));
    for (int k = 0; k < exp_rx.size() && k < rx_q.size(); k++)
      check($sformatf("%s_rx%0d", tag, k), 32'(rx_q[k]), 32'(exp_rx[k]));
    check({tag, "_err"}, 32'(err_log.size()), 32'd0);
  endtask

  task automatic run_burst(input string tag, input logic [NUM_REQ-1:0] mask,
                           input logic [NUM_REQ*8-1:0] data, input bit hold, input int count);
    clear_logs();
    model_expect(mask, data, hold, count);
    hold_mode    = hold;
    target       = count;
    bus.req_data = data;
    bus.req      = mask;
    wait_done(tag, count);
    compare(tag);
    hold_mode = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ*8-1:0] data;
    int n;

    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) step();
    check_reset("reset");
    reset = 1'b1;
    step();

    run_burst("contend", 4'hF, 32'h43322110, 1'b0, 4);
    run_burst("fair", 4'b1001, 32'h9C00005A, 1'b1, 4);

    // Single request: ack on the first edge, uart_start one cycle later.
    clear_logs();
    model_expect(4'b0100, 32'h00AA0000, 1'b0, 1);
    bus.req_data = 32'h00AA0000;
    bus.req      = 4'b0100;
    step();
    check("single_ack", 32'(bus.ack), 32'h4);
    check("single_gid", 32'(bus.grant_id), 32'd2);
    check("single_active", 32'(bus.active), 32'd1);
    check("single_nostart", 32'(bus.uart_start), 32'd0);
    step();
    check("single_start", 32'(bus.uart_start), 32'd1);
    check("single_data", 32'(bus.uart_send_data), TAG_ON ? 32'hF2 : 32'hAA);
    wait_done("single", 1);
    compare("single");

    // Busy never rises: one start, err WAIT_HI_MAX cycles later, back to idle.
    clear_logs();
    uart_en      = 1'b0;
    bus.req_data = 32'h00006100;
    bus.req      = 4'b0010;
    n = 0;
    while (err_log.size() == 0 && n < 200) begin
      step();
      n++;
      if (bus.err === 1'b1) check("timeout_active", 32'(bus.active), 32'd0);
    end
    check("timeout_seen", 32'(n < 200), 32'd1);
    check("timeout_acks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() > 0) check("timeout_ack_id", 32'(ack_log[0]), 32'd1);
    if (start_log.size() > 0 && err_log.size() > 0)
      check("timeout_delay", 32'(err_log[0] - start_log[0]), 32'(WAIT_HI_MAX));
    repeat (5) step();
    check("timeout_starts", 32'(start_log.size()), 32'd1);
    check("timeout_errs", 32'(err_log.size()), 32'd1);
    check("timeout_idle", 32'(bus.active), 32'd0);
    uart_en    = 1'b1;
    model_last = 1;

    // Request withdrawn while the UART is busy: never acknowledged.
    clear_logs();
    busy_force = 1'b1;
    repeat (2) step();
    bus.req_data = 32'h00007700;
    bus.req      = 4'b0010;
    repeat (3) step();
    bus.req = '0;
    step();
    busy_force = 1'b0;
    repeat (10) step();
    check("withdraw_acks", 32'(ack_log.size()), 32'd0);
    check("withdraw_starts", 32'(start_log.size()), 32'd0);

    // Busy in idle blocks arbitration until it falls.
    clear_logs();
    busy_force   = 1'b1;
    bus.req_data = 32'h3C000000;
    bus.req      = 4'b1000;
    repeat (4) step();
    check("blocked_acks", 32'(ack_log.size()), 32'd0);
    busy_force = 1'b0;
    run_burst("unblocked", 4'b1000, 32'h3C000000, 1'b0, 1);

    // Reset while the data frame is on the line.
    clear_logs();
    bus.req_data = 32'h00770000;
    bus.req      = 4'b0100;
    n = 0;
    while (!(start_log.size() == (TAG_ON ? 2 : 1) && bus.uart_busy === 1'b1) && n < 200) begin
      step();
      n++;
    end
    check("midframe_reached", 32'(n < 200), 32'd1);
    step();
    check("midframe_gid", 32'(bus.grant_id), 32'd2);
    check("midframe_active", 32'(bus.active), 32'd1);
    reset = 1'b0;
    step();
    check_reset("midframe_reset");
    reset      = 1'b1;
    model_last = NUM_REQ - 1;
    n = 0;
    while (bus.uart_busy === 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("midframe_acks", 32'(ack_log.size()), 32'd1);
    run_burst("after_reset", 4'b0001, 32'h00000055, 1'b0, 1);

    for (int r = 0; r < 8; r++) begin
      mask = NUM_REQ'($urandom_range(15, 1));
      data = $urandom;
      run_burst($sformatf("rand%0d", r), mask, data, 1'b0, $countones(mask));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
